// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with flush/load-use bubbles, stall hold, optional ID_EX_BUBBLE_COUNT_EN counter
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [18:0]       id_ctrl,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  output logic              ex_valid,
  output logic [18:0]       ex_ctrl,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [RA_W-1:0]   ex_rs,
  output logic [RA_W-1:0]   ex_rt,
  output logic [RA_W-1:0]   ex_rd,
  output logic              stall_req
`ifdef ID_EX_BUBBLE_COUNT_EN
  ,
  output logic [15:0]       bubble_count
`endif
);
  logic rs_used, rt_used, load_use, bubble;
  assign rs_used   = !(id_ctrl[17:16] == 2'b01 || id_ctrl[18]);
  assign rt_used   = !id_ctrl[6] || id_ctrl[12];
  assign load_use  = ex_valid && ex_ctrl[13] && (ex_rt != '0) && id_valid &&
                     ((rs_used && id_rs == ex_rt) || (rt_used && id_rt == ex_rt));
  assign stall_req = load_use && !flush;
  assign bubble    = flush || (!stall && load_use);
  always_ff @(posedge clk or posedge rst) begin
    if (rst || bubble) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_pc4     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
    end else if (!stall) begin
      ex_valid   <= id_valid;
      ex_ctrl    <= id_valid ? id_ctrl : '0;
      ex_pc4     <= id_pc4;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
    end
  end
`ifdef ID_EX_BUBBLE_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bubble_count <= '0;
    else if (bubble && bubble_count != 16'hFFFF) bubble_count <= bubble_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed plus random checks of id_ex_stage_reg against an instruction-level model
module tb_id_ex_stage_reg;
  logic clk = 1'b0, rst = 1'b0, stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
  logic [18:0] id_ctrl = '0;
  logic [31:0] id_pc4 = '0, id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic        ex_valid, stall_req;
  logic [18:0] ex_ctrl;
  logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [15:0] bubble_count;
`endif
  int n_cmp = 0, n_bad = 0;
  int unsigned exp_cnt = 0;

  typedef struct packed {
    logic        v;
    logic [18:0] c;
    logic [31:0] pc4, rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
  } ent_t;
  ent_t m = '0;

  id_ex_stage_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_ctrl(id_ctrl), .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .stall_req(stall_req)
`ifdef ID_EX_BUBBLE_COUNT_EN
    , .bubble_count(bubble_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Does the instruction in decode read a register that the load sitting in EX will write?
  function automatic logic hazard(input ent_t e);
    logic is_load, reads_rs, reads_rt;
    is_load  = e.v && e.c[13] && e.rt != 5'd0;
    reads_rs = !(id_ctrl[18] || id_ctrl[17:16] == 2'b01);
    reads_rt = !id_ctrl[6] || id_ctrl[12];
    return is_load && id_valid && ((reads_rs && id_rs == e.rt) || (reads_rt && id_rt == e.rt));
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(m.v));
    chk({tag, ".ex_ctrl"}, 32'(ex_ctrl), 32'(m.c));
    chk({tag, ".ex_pc4"}, ex_pc4, m.pc4);
    chk({tag, ".ex_rs_data"}, ex_rs_data, m.rsd);
    chk({tag, ".ex_rt_data"}, ex_rt_data, m.rtd);
    chk({tag, ".ex_imm"}, ex_imm, m.imm);
    chk({tag, ".ex_regs"}, {17'd0, ex_rs, ex_rt, ex_rd}, {17'd0, m.rs, m.rt, m.rd});
`ifdef ID_EX_BUBBLE_COUNT_EN
    chk({tag, ".bubble_count"}, 32'(bubble_count), exp_cnt);
`endif
  endtask

  task automatic step(input string tag);
    ent_t nx;
    logic lu;
    #1;
    lu = hazard(m);
    chk({tag, ".stall_req"}, 32'(stall_req), 32'(lu && !flush));
    if (flush || (!stall && lu)) begin
      nx = '0;
      if (exp_cnt < 65535) exp_cnt++;
    end else if (stall) nx = m;
    else nx = '{id_valid, id_valid ? id_ctrl : 19'd0, id_pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd};
    @(posedge clk);
    #1;
    m = nx;
    check_all(tag);
  endtask

  task automatic set_id(input logic v, input logic [18:0] c, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
    id_pc4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check_all("reset");
    chk("reset.stall_req", 32'(stall_req), 32'd0);
    #1 rst = 1'b0;
    set_id(1, 19'h04A80, 5'd1, 5'd2, 5'd3);
    id_rs_data = 32'h1234;
    step("capture");
    chk("capture.literal_ctrl", 32'(ex_ctrl), 32'h04A80);
    chk("capture.literal_rs_data", ex_rs_data, 32'h1234);
    set_id(1, 19'h06040, 5'd4, 5'd8, 5'd0);
    step("lw_into_ex");
    set_id(1, 19'h04A80, 5'd8, 5'd9, 5'd10);
    #1 chk("load_use.stall_req_lit", 32'(stall_req), 32'd1);
    step("load_use_bubble");
    chk("load_use.bubble_valid_lit", 32'(ex_valid), 32'd0);
    step("load_use_retry");
    chk("load_use.retry_valid_lit", 32'(ex_valid), 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 19'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      step("stall_hold");
    end
    flush = 1'b1;
    step("flush_and_stall");
    stall = 1'b0; flush = 1'b0;
    set_id(1, 19'h06040, 5'd1, 5'd0, 5'd0);
    step("lw_rt0");
    set_id(1, 19'h04A80, 5'd0, 5'd0, 5'd5);
    step("rt0_no_hazard");
    set_id(1, 19'h06040, 5'd1, 5'd7, 5'd0);
    step("lw_rt7");
    set_id(1, 19'h04A80, 5'd7, 5'd3, 5'd5);
    flush = 1'b1;
    step("flush_over_load_use");
    flush = 1'b0;
    set_id(1, 19'h04A80, 5'd1, 5'd2, 5'd3);
    step("pre_async_reset");
    @(posedge clk);
    m = '{1'b1, 19'h04A80, id_pc4, id_rs_data, id_rt_data, id_imm, 5'd1, 5'd2, 5'd3};
    #3 rst = 1'b1;
    m = '0;
    exp_cnt = 0;
    #1 check_all("async_reset");
    chk("async_reset.stall_req", 32'(stall_req), 32'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 3) != 0, 19'($urandom), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom));
      stall = $urandom_range(0, 4) == 0;
      flush = $urandom_range(0, 6) == 0;
      step("random");
    end
`ifdef ID_EX_BUBBLE_COUNT_EN
    stall = 1'b0;
    flush = 1'b1;
    repeat (65540) @(posedge clk);
    #1 chk("bubble_count.saturate", 32'(bubble_count), 32'hFFFF);
    exp_cnt = 65535;
    step("bubble_count.hold_saturated");
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
